// File: rtl/condicionador_botoes.sv
// condicionador_botoes: synchronises, debounces and one-hot encodes four push-buttons.
// Optional stuck-button detection is enabled by defining BOTAO_PRESO_EN.
module condicionador_botoes #(
  parameter int DEBOUNCE_CICLOS = 2500,
  parameter int PRESO_CICLOS    = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       multiplo,
  output logic       botao_preso,
  output logic [2:0] db_estado
);
  localparam int MAXC = DEBOUNCE_CICLOS > PRESO_CICLOS ? DEBOUNCE_CICLOS : PRESO_CICLOS;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DB_FIM = CW'(DEBOUNCE_CICLOS - 1);
`ifdef BOTAO_PRESO_EN
  localparam logic [CW-1:0] PRESO_FIM = CW'(PRESO_CICLOS);
  localparam logic [CW-1:0] PRESO_ANT = CW'(PRESO_CICLOS - 1);
`endif
  typedef enum logic [2:0] {
    ESPERA    = 3'd0,
    FILTRANDO = 3'd1,
    REGISTRA  = 3'd2,
    SEGURANDO = 3'd3,
    LIBERANDO = 3'd4,
    ERRO      = 3'd5
  } estado_t;
  estado_t estado, prox;
  logic [3:0] s1, s, amostra, amostra_n;
  logic [CW-1:0] cnt, cnt_n;
  logic vazio, unico;
  assign vazio = s == 4'b0000;
  assign unico = !vazio && ((s & (s - 4'd1)) == 4'b0000);
  assign jogada_feita = estado == REGISTRA;
  assign multiplo = estado == ERRO;
  assign db_estado = estado;
`ifdef BOTAO_PRESO_EN
  logic preso_n;
  always_ff @(posedge clock or posedge reset)
    if (reset) botao_preso <= 1'b0;
    else botao_preso <= preso_n;
`else
  assign botao_preso = 1'b0;
`endif
  always_comb begin
    prox = estado;
    amostra_n = amostra;
    cnt_n = cnt;
`ifdef BOTAO_PRESO_EN
    preso_n = botao_preso;
`endif
    case (estado)
      ESPERA:
        if (!vazio) begin
          if (!habilita) begin
            prox = SEGURANDO;
            cnt_n = '0;
          end else if (unico) begin
            prox = FILTRANDO;
            amostra_n = s;
            cnt_n = '0;
          end else prox = ERRO;
        end
      FILTRANDO:
        if (vazio) prox = ESPERA;
        else if (!unico) prox = ERRO;
        else if (s != amostra) begin
          amostra_n = s;
          cnt_n = '0;
        end else if (cnt == DB_FIM) prox = REGISTRA;
        else cnt_n = cnt + 1'b1;
      REGISTRA, ERRO: begin
        prox = SEGURANDO;
        cnt_n = '0;
      end
      SEGURANDO:
        if (vazio) begin
          prox = LIBERANDO;
          cnt_n = '0;
`ifdef BOTAO_PRESO_EN
          preso_n = 1'b0;
        end else begin
          if (cnt != PRESO_FIM) cnt_n = cnt + 1'b1;
          if (cnt >= PRESO_ANT) preso_n = 1'b1;
`endif
        end
      LIBERANDO:
        if (!vazio) begin
          prox = SEGURANDO;
          cnt_n = '0;
        end else if (cnt == DB_FIM) prox = ESPERA;
        else cnt_n = cnt + 1'b1;
      default: prox = ESPERA;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1 <= 4'b0;
      s <= 4'b0;
      estado <= ESPERA;
      amostra <= 4'b0;
      cnt <= '0;
      jogada <= 4'b0;
    end else begin
      s1 <= botoes;
      s <= s1;
      estado <= prox;
      amostra <= amostra_n;
      cnt <= cnt_n;
      if (estado == REGISTRA) jogada <= amostra;
    end
endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
- Input conditioner that sits directly upstream of the game datapath's `botoes` input.
- Synchronises the four raw push-buttons and debounces them.
- Converts each valid press into a single registered one-hot jogada plus a one-cycle `jogada_feita` strobe.
- Rejects multi-button presses and requires a clean release before the next press is accepted.

Parameters:
- DEBOUNCE_CICLOS, 2500, consecutive stable cycles needed to accept a press and also to accept a release; minimum 1.
- PRESO_CICLOS, 50000000, cycles a press may be held before `botao_preso` asserts (used only with the optional feature).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- botoes  input  4  raw, asynchronous buttons; active-high, one bit per colour.
- habilita  input  1  presses are accepted only while high.
- jogada  output  4  one-hot code of the last accepted press; registered.
- jogada_feita  output  1  one-cycle strobe marking an accepted press.
- multiplo  output  1  one-cycle strobe marking a rejected multi-button press.
- botao_preso  output  1  level; a button has been held too long (optional feature).
- db_estado  output  3  current FSM state code.

Behaviour:
- Reset: one clock and one asynchronous, active-high reset named reset. Reset forces:
  - state ESPERA;
  - synchroniser flops, sample register and counter to 0;
  - jogada=0000;
  - jogada_feita=0, multiplo=0, botao_preso=0, db_estado=000.
- Reset asserted mid-operation aborts the current state immediately. No strobe is emitted.
- Synchroniser: 2-flop synchroniser on botoes produces s. All decisions use s only.
- Counter: width $clog2(max(DEBOUNCE_CICLOS, PRESO_CICLOS))+1, unsigned, no wrap.
- FSM states (code):
  - ESPERA(0):
    - s=0: stay.
    - s≠0 and habilita=0: go SEGURANDO. The press is consumed silently.
    - s one-hot and habilita=1: go FILTRANDO; amostra<=s, cnt<=0.
    - s has ≥2 bits and habilita=1: go ERRO.
  - FILTRANDO(1):
    - s=0: go ESPERA.
    - s has ≥2 bits: go ERRO.
    - s one-hot ≠ amostra: stay; amostra<=s, cnt<=0.
    - s=amostra and cnt=DEBOUNCE_CICLOS-1: go REGISTRA.
    - otherwise: cnt++.
  - REGISTRA(2):
    - jogada<=amostra; jogada_feita=1 for this cycle only.
    - Unconditional next state SEGURANDO.
  - ERRO(5): multiplo=1 for this cycle only; jogada unchanged; next state SEGURANDO.
  - SEGURANDO(3):
    - s=0: go LIBERANDO; cnt<=0.
    - otherwise: stay; the preso counter runs.
  - LIBERANDO(4):
    - s≠0: go SEGURANDO (bounce on release).
    - s=0 and cnt=DEBOUNCE_CICLOS-1: go ESPERA.
    - otherwise: cnt++.
- Latency:
  - A raw press first sampled at edge k, stable thereafter, puts the FSM in REGISTRA after edge k+3+DEBOUNCE_CICLOS-1.
  - With DEBOUNCE_CICLOS=4, jogada_feita is high during the 7th cycle.
- Outputs: jogada_feita and multiplo are Moore-decoded from state. jogada holds its value until the next REGISTRA. A falling habilita does not clear jogada.
- habilita: sampled only in ESPERA. Dropping habilita during FILTRANDO does not abort the press.
- Gap between presses: back-to-back presses require at least DEBOUNCE_CICLOS zero cycles between them. A faster re-press is not a new jogada.
- Exclusivity: jogada_feita and multiplo never assert in the same cycle.

Optional Feature:
- Macro: BOTAO_PRESO_EN.
- Defined:
  - In SEGURANDO the counter increments each cycle.
  - When it reaches PRESO_CICLOS, botao_preso goes to 1 and stays high.
  - botao_preso clears on entry to LIBERANDO or on reset.
  - The counter saturates.
  - A bounce LIBERANDO→SEGURANDO restarts the count from 0.
- Undefined: botao_preso is tied to 0, no counter is used in SEGURANDO, and the port is still present.

Test Plan (DEBOUNCE_CICLOS=4, PRESO_CICLOS=20, BOTAO_PRESO_EN defined):
- Clean press: habilita=1, botoes=0100 held 20 cycles, then 0000 -> single jogada_feita pulse 7 cycles after the press; jogada=0100; db_estado returns to 0 after 5 zero cycles.
- Bounce: botoes toggles 0010/0000 every 2 cycles for 10 cycles, then holds 0010 -> no pulse during toggling; exactly one pulse 7 cycles after the stable hold; jogada=0010.
- Multi-button: botoes=0011 for 10 cycles -> multiplo=1 for one cycle; jogada_feita stays 0; jogada keeps its previous value; FSM stays in SEGURANDO until release.
- Disabled: habilita=0, press 1000, then raise habilita while still held -> no jogada_feita; jogada unchanged; release then press 1000 again -> pulse with jogada=1000.
- Held button: press 0001 for 40 cycles -> jogada_feita once; botao_preso rises 20 cycles after entering SEGURANDO; botao_preso clears the cycle after release is synchronised.
- Async reset while in FILTRANDO -> all outputs 0 immediately (no clock edge); the held button after reset release is treated as a new press and pulses 7 cycles later.
